// File: rtl/loader_pkg.sv
// Shared state encoding, widths and word-packing helper for the RAM512 loader.
package loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4
  } state_e;

  // Stream is big-endian: the first byte of a pair lands in the upper half.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Byte-pair holding register for the RAM loader: latches high/low bytes of a word and
// the end-of-stream flag; capturing a high byte pre-pads the low byte for odd streams.
module loader_byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              cap_hi,
  input  logic              cap_lo,
  input  logic [BYTE_W-1:0] data,
  input  logic              last_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  logic [BYTE_W-1:0] hi_r;
  logic [BYTE_W-1:0] lo_r;
  logic              last_r;

  // Byte and last-flag capture; a lone final high byte leaves the low byte at 8'h00.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_r   <= 8'h00;
      lo_r   <= 8'h00;
      last_r <= 1'b0;
    end else if (clear) begin
      hi_r   <= 8'h00;
      lo_r   <= 8'h00;
      last_r <= 1'b0;
    end else if (cap_hi) begin
      hi_r   <= data;
      lo_r   <= 8'h00;
      last_r <= last_in;
    end else if (cap_lo) begin
      lo_r   <= data;
      last_r <= last_in;
    end else begin
      hi_r   <= hi_r;
      lo_r   <= lo_r;
      last_r <= last_r;
    end
  end

  assign word = pack_word(hi_r, lo_r);
  assign last = last_r;

endmodule

// File: rtl/ram_loader.sv
// Write-side feeder for RAM512: packs an ioctl byte stream into sequential 16-bit writes
// or clears the RAM. Optional build macro LOADER_CHECKSUM_EN enables the running checksum.
module ram_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter logic [WORD_W-1:0] CLEAR_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_load,
  input  logic              start_clear,
  input  logic              dl_valid,
  input  logic [BYTE_W-1:0] dl_data,
  input  logic              dl_last,
  output logic              dl_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] ram_in,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WC_ZERO   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   WC_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_r;
  state_e            next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   word_count_r;
  logic              overflow_r;
  logic              done_r;

  logic              dl_ready_s;
  logic              busy_s;
  logic              wr_en_s;
  logic [WORD_W-1:0] wr_data_s;
  logic              cap_hi_s;
  logic              cap_lo_s;
  logic              start_s;
  logic              xfer_s;
  logic              full_s;
  logic [WORD_W-1:0] pk_word_s;
  logic              pk_last_s;

  // A start only counts when taken from IDLE; that is also where per-run state is zeroed.
  assign start_s = (state_r == IDLE) && (start_load || start_clear);
  assign xfer_s  = dl_valid && dl_ready_s;
  assign full_s  = (word_count_r == DEPTH);

  loader_byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_s),
    .cap_hi  (cap_hi_s),
    .cap_lo  (cap_lo_s),
    .data    (dl_data),
    .last_in (dl_last),
    .word    (pk_word_s),
    .last    (pk_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; clear has priority over load when both start together.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_clear) begin
          next_state_s = CLEAR;
        end else if (start_load) begin
          next_state_s = HI;
        end else begin
          next_state_s = IDLE;
        end
      end
      HI: begin
        if (xfer_s) begin
          next_state_s = dl_last ? WRITE : LO;
        end else begin
          next_state_s = HI;
        end
      end
      LO: begin
        if (xfer_s) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = LO;
        end
      end
      WRITE:   next_state_s = pk_last_s ? IDLE : HI;
      CLEAR:   next_state_s = (addr_r == LAST_ADDR) ? IDLE : CLEAR;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; once DEPTH words are stored, WRITE still consumes the word but drops it.
  always_comb begin
    dl_ready_s = 1'b0;
    busy_s     = 1'b1;
    wr_en_s    = 1'b0;
    wr_data_s  = pk_word_s;
    cap_hi_s   = 1'b0;
    cap_lo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      HI: begin
        dl_ready_s = 1'b1;
        cap_hi_s   = dl_valid;
      end
      LO: begin
        dl_ready_s = 1'b1;
        cap_lo_s   = dl_valid;
      end
      WRITE: begin
        wr_en_s = !full_s;
      end
      CLEAR: begin
        wr_en_s   = 1'b1;
        wr_data_s = CLEAR_VALUE;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Address, word counter, overflow and completion pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_r       <= ADDR_ZERO;
      word_count_r <= WC_ZERO;
      overflow_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            addr_r       <= ADDR_ZERO;
            word_count_r <= WC_ZERO;
            overflow_r   <= 1'b0;
          end
        end
        WRITE: begin
          if (full_s) begin
            overflow_r <= 1'b1;
          end else begin
            addr_r       <= addr_r + ADDR_ONE;
            word_count_r <= word_count_r + WC_ONE;
          end
          done_r <= pk_last_s;
        end
        CLEAR: begin
          addr_r       <= addr_r + ADDR_ONE;
          word_count_r <= word_count_r + WC_ONE;
          done_r       <= (addr_r == LAST_ADDR);
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_r;

  // Wrapping sum of every word actually committed to the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum_r <= 16'h0000;
    end else if (start_s) begin
      checksum_r <= 16'h0000;
    end else if (wr_en_s) begin
      checksum_r <= checksum_r + wr_data_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 16'h0000;
`endif

  assign dl_ready    = dl_ready_s;
  assign busy        = busy_s;
  assign ram_load    = wr_en_s;
  assign ram_address = wr_en_s ? addr_r : ADDR_ZERO;
  assign ram_in      = wr_en_s ? wr_data_s : 16'h0000;
  assign done        = done_r;
  assign overflow    = overflow_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_ram_loader.sv
// Randomised self-checking bench for ram_loader: byte streams and clears are compared
// against an array-based model of the expected RAM contents and status outputs.
module tb_ram_loader;

  localparam int          ADDR_W = 9;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [15:0] CV     = 16'h5A3C;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start_load;
  logic              start_clear;
  logic              dl_valid;
  logic [7:0]        dl_data;
  logic              dl_last;
  logic              dl_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [15:0]       ram_in;
  logic              ram_load;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [15:0]       checksum;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(ADDR_W), .CLEAR_VALUE(CV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_load  (start_load),
    .start_clear (start_clear),
    .dl_valid    (dl_valid),
    .dl_data     (dl_data),
    .dl_last     (dl_last),
    .dl_ready    (dl_ready),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .word_count  (word_count),
    .checksum    (checksum)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every RAM write observed, plus protocol counters.
  logic [ADDR_W-1:0] obs_addr [0:4095];
  logic [15:0]       obs_data [0:4095];
  int obs_n       = 0;
  int cyc         = 0;
  int last_wr_cyc = 0;
  int done_cyc    = 0;
  int done_cnt    = 0;
  int rdy_wr_cnt  = 0;
  int gate_cnt    = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ram_load === 1'b1) begin
      if (obs_n < 4096) begin
        obs_addr[obs_n] <= ram_address;
        obs_data[obs_n] <= ram_in;
      end
      obs_n       <= obs_n + 1;
      last_wr_cyc <= cyc;
      if (dl_ready === 1'b1) rdy_wr_cnt <= rdy_wr_cnt + 1;
    end else if (ram_address !== '0 || ram_in !== 16'h0000) begin
      gate_cnt <= gate_cnt + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Reference model: the stream as bytes, the words it should produce.
  logic [7:0]  stream [0:2047];
  int          slen;
  logic [15:0] exp_w  [0:1023];
  int          exp_nw;

  task automatic build_model();
    exp_nw = (slen + 1) / 2;
    for (int i = 0; i < exp_nw; i++) begin
      exp_w[i] = {stream[2*i], ((2*i + 1) < slen) ? stream[2*i + 1] : 8'h00};
    end
  endtask

  task automatic fill_random(input int n);
    slen = n;
    for (int i = 0; i < n; i++) stream[i] = 8'($urandom);
  endtask

  task automatic drive_stream(input int gap_pct, input int stop_after, input int base,
                              output bit aborted);
    int idx    = 0;
    int used   = 0;
    int budget = 8 * slen + 200;
    aborted = 1'b0;
    while (idx < slen && used < budget) begin
      @(negedge clk);
      used++;
      if (stop_after > 0 && (obs_n - base) >= stop_after) begin
        aborted = 1'b1;
        break;
      end
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        dl_valid = 1'b0;
        dl_data  = 8'($urandom);
        dl_last  = 1'($urandom);
      end else begin
        dl_valid = 1'b1;
        dl_data  = stream[idx];
        dl_last  = (idx == slen - 1);
      end
      if (dl_valid && dl_ready === 1'b1) idx++;
    end
    if (!aborted) begin
      if (idx < slen) check("stream_timeout", idx, slen);
      @(negedge clk);
      dl_valid = 1'b0;
      dl_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  task automatic run_load(input string tag, input int gap_pct, output int base);
    int dbase, rbase, gbase, mism, nexp;
    bit ab;
    logic [15:0] cks;
    base  = obs_n;
    dbase = done_cnt;
    rbase = rdy_wr_cnt;
    gbase = gate_cnt;
    build_model();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    drive_stream(gap_pct, 0, base, ab);
    wait_done(100);
    nexp = (exp_nw > DEPTH) ? DEPTH : exp_nw;
    mism = 0;
    cks  = 16'h0000;
    for (int i = 0; i < nexp; i++) begin
      cks += exp_w[i];
      if (obs_addr[base + i] !== ADDR_W'(i) || obs_data[base + i] !== exp_w[i]) mism++;
    end
    check($sformatf("%s_writes", tag), obs_n - base, nexp);
    check($sformatf("%s_data_mism", tag), mism, 0);
    check($sformatf("%s_word_count", tag), word_count, nexp);
    check($sformatf("%s_overflow", tag), overflow, (exp_nw > DEPTH) ? 1 : 0);
    check($sformatf("%s_done_pulses", tag), done_cnt - dbase, 1);
    check($sformatf("%s_ready_in_write", tag), rdy_wr_cnt - rbase, 0);
    check($sformatf("%s_ungated", tag), gate_cnt - gbase, 0);
    if (exp_nw <= DEPTH) check($sformatf("%s_done_lat", tag), done_cyc - last_wr_cyc, 1);
`ifdef LOADER_CHECKSUM_EN
    check($sformatf("%s_checksum", tag), checksum, cks);
`else
    check($sformatf("%s_checksum", tag), checksum, 16'h0000);
`endif
  endtask

  task automatic run_clear(input bit both, input bit poke);
    int base, dbase, gbase, first, mism;
    logic [15:0] cks;
    base  = obs_n;
    dbase = done_cnt;
    gbase = gate_cnt;
    start_clear = 1'b1;
    start_load  = both;
    @(negedge clk);
    start_clear = 1'b0;
    start_load  = 1'b0;
    check("clr_first_load", ram_load, 1'b1);
    check("clr_first_ready", dl_ready, 1'b0);
    first = cyc;
    if (poke) begin
      repeat (5) @(negedge clk);
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
    end
    wait_done(DEPTH + 50);
    mism = 0;
    cks  = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      cks += CV;
      if (obs_addr[base + i] !== ADDR_W'(i) || obs_data[base + i] !== CV) mism++;
    end
    check("clr_writes", obs_n - base, DEPTH);
    check("clr_data_mism", mism, 0);
    check("clr_word_count", word_count, DEPTH);
    check("clr_overflow", overflow, 1'b0);
    check("clr_done_pulses", done_cnt - dbase, 1);
    check("clr_duration", done_cyc - first, DEPTH);
    check("clr_ungated", gate_cnt - gbase, 0);
`ifdef LOADER_CHECKSUM_EN
    check("clr_checksum", checksum, cks);
`else
    check("clr_checksum", checksum, 16'h0000);
`endif
    repeat (3) @(negedge clk);
    check("clr_stays_idle", busy, 1'b0);
    check("clr_no_ready", dl_ready, 1'b0);
  endtask

  initial begin
    int  b;
    int  snap;
    bit  ab;
    reset_n     = 1'b0;
    start_load  = 1'b0;
    start_clear = 1'b0;
    dl_valid    = 1'b0;
    dl_data     = 8'h00;
    dl_last     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ram_load", ram_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", dl_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outs", {overflow, word_count, checksum, ram_address, ram_in}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Even-length directed stream.
    slen = 4;
    stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'hAB; stream[3] = 8'hCD;
    run_load("t1", 0, b);
    check("t1_w0", {7'(0), obs_addr[b], obs_data[b]}, {7'(0), 9'd0, 16'h1234});
    check("t1_w1", {7'(0), obs_addr[b+1], obs_data[b+1]}, {7'(0), 9'd1, 16'hABCD});
`ifdef LOADER_CHECKSUM_EN
    check("t1_cks_value", checksum, 16'hBE01);
`endif

    // Odd-length directed stream.
    slen = 3;
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
    run_load("t2", 30, b);
    check("t2_w1", obs_data[b+1], 16'h0300);

    for (int k = 0; k < 10; k++) begin
      fill_random($urandom_range(1, 40));
      run_load("rnd", $urandom_range(0, 50), b);
    end

    // 1026 bytes = 513 words: the last one is dropped.
    fill_random(1026);
    run_load("ovf", 10, b);

    fill_random($urandom_range(1, 20));
    run_load("post_ovf", 20, b);

    run_clear(1'b1, 1'b1);
    run_clear(1'b0, 1'b0);

    // Reset in the middle of a load.
    fill_random(20);
    b = obs_n;
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    drive_stream(0, 3, b, ab);
    check("rst_mid_reached", ab, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ram_load", ram_load, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", dl_ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_outs", {overflow, word_count, checksum, ram_address, ram_in}, 32'h0);
    snap = obs_n;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    dl_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_no_writes", obs_n - snap, 0);
    check("mid_rst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
